// File: rtl/sram_bridge.sv
// sram_bridge: clocked bridge between the AVR-side pins and an asynchronous SRAM.
// Loads the SRAM address serially, runs each read/write as SETUP, ACCESS
// (WAIT_STATES cycles) and HOLD, optionally increments the address after each
// access and returns read data with a one-cycle valid pulse.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_si, i_sreg_en      serial address bit (MSB first) and shift enable
//   i_autoinc            increment the address after each completed access
//   i_cmd_valid/o_cmd_ready, i_cmd_we, i_wdata   access request handshake
//   o_rdata, o_rdata_valid                       read data and update pulse
//   o_sram_addr, o_sram_dout, i_sram_din, o_sram_data_oe,
//   o_sram_ce_n, o_sram_oe_n, o_sram_we_n        registered SRAM pins
//   o_debug              {latched we, 1'b0, state[1:0]}
module sram_bridge #(
  parameter int unsigned ADDR_WIDTH  = 21,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_si,
  input  logic                  i_sreg_en,
  input  logic                  i_autoinc,
  input  logic                  i_cmd_valid,
  input  logic                  i_cmd_we,
  output logic                  o_cmd_ready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rdata_valid,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_dout,
  input  logic [DATA_WIDTH-1:0] i_sram_din,
  output logic                  o_sram_data_oe,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n,
  output logic [3:0]            o_debug
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StHold   = 2'd3
  } state_e;

  // ACCESS lasts WAIT_STATES cycles: count down from WAIT_STATES-1 to 0.
  localparam logic [3:0] CntInit = 4'(WAIT_STATES - 1);

  state_e                r_state;
  state_e                w_state_d;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdata_valid;
  logic                  r_data_oe;
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;

  logic                  w_accept;
  logic                  w_we_next;
  logic                  w_strobe_d;

  assign w_accept  = i_cmd_valid && (r_state == StIdle);
  // Direction of the access the next state belongs to.
  assign w_we_next = w_accept ? i_cmd_we : r_we;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (i_cmd_valid) w_state_d = StSetup;
      StSetup:  w_state_d = StAccess;
      StAccess: if (r_cnt == 4'd0) w_state_d = StHold;
      StHold:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  assign w_strobe_d = (w_state_d == StSetup) || (w_state_d == StAccess);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_cnt         <= 4'd0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_dout        <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_data_oe     <= 1'b0;
      r_ce_n        <= 1'b1;
      r_oe_n        <= 1'b1;
      r_we_n        <= 1'b1;
    end else begin
      r_state <= w_state_d;

      if (w_accept) begin
        r_we <= i_cmd_we;
        if (i_cmd_we) r_dout <= i_wdata;
      end

      if (r_state == StSetup) begin
        r_cnt <= CntInit;
      end else if (r_state == StAccess && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // An accepted command takes priority over a same-cycle shift.
      if (r_state == StIdle && !w_accept && i_sreg_en) begin
        r_addr <= {r_addr[ADDR_WIDTH-2:0], i_si};
      end else if (r_state == StHold && i_autoinc) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end

      if (r_state == StAccess && r_cnt == 4'd0 && !r_we) begin
        r_rdata <= i_sram_din;
      end

      // Pins are registered from the next state so they line up with it.
      r_ce_n        <= !w_strobe_d;
      r_oe_n        <= !(w_strobe_d && !w_we_next);
      r_we_n        <= !(w_state_d == StAccess && w_we_next);
      r_data_oe     <= w_we_next && (w_state_d != StIdle);
      r_rdata_valid <= !w_we_next && (w_state_d == StHold);
    end
  end

  assign o_cmd_ready    = (r_state == StIdle);
  assign o_rdata        = r_rdata;
  assign o_rdata_valid  = r_rdata_valid;
  assign o_sram_addr    = r_addr;
  assign o_sram_dout    = r_dout;
  assign o_sram_data_oe = r_data_oe;
  assign o_sram_ce_n    = r_ce_n;
  assign o_sram_oe_n    = r_oe_n;
  assign o_sram_we_n    = r_we_n;
  assign o_debug        = {r_we, 1'b0, r_state};

endmodule
